brick_scan: RTL and testbench

//  Reader side of the brick health RAM that the level loader fills. On a start pulse it

---
 rtl/brick_scan_pkg.sv | 8 +
 rtl/brick_tally_acc.sv | 42 ++++
 rtl/brick_scan.sv | 94 +++++++++
 tb/tb_brick_scan.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/brick_scan_pkg.sv
// brick_scan_pkg: shared widths, health encoding and FSM states for the brick scanner
package brick_scan_pkg;
  localparam int BRICKNUM = 128;
  localparam int ADDR_W = 10;
  localparam int HEALTH_W = 2;
  localparam logic [HEALTH_W-1:0] HEALTH_NONE = 2'd0;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/brick_tally_acc.sv
// brick_tally_acc: per-health accumulators fed by qualified RAM samples
module brick_tally_acc
  import brick_scan_pkg::*;
#(
  parameter int CNT_W = 11
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clear_i,
  input  logic                valid_i,
  input  logic [HEALTH_W-1:0] health_i,
  output logic [CNT_W-1:0]    total_o,
  output logic [CNT_W-1:0]    hp1_o,
  output logic [CNT_W-1:0]    hp2_o,
  output logic [CNT_W-1:0]    hp3_o
);
  logic [CNT_W-1:0] total_q, total_d, hp1_q, hp1_d, hp2_q, hp2_d, hp3_q, hp3_d;
  // valid_i gates every term so unqualified (possibly X) health never counts
  always_comb begin
    total_d = total_q + CNT_W'(valid_i && health_i != HEALTH_NONE);
    hp1_d   = hp1_q + CNT_W'(valid_i && health_i == 2'd1);
    hp2_d   = hp2_q + CNT_W'(valid_i && health_i == 2'd2);
    hp3_d   = hp3_q + CNT_W'(valid_i && health_i == 2'd3);
  end
  always_ff @(posedge clk) begin
    if (!resetn || clear_i) begin
      total_q <= '0;
      hp1_q   <= '0;
      hp2_q   <= '0;
      hp3_q   <= '0;
    end else begin
      total_q <= total_d;
      hp1_q   <= hp1_d;
      hp2_q   <= hp2_d;
      hp3_q   <= hp3_d;
    end
  end
  assign total_o = total_q;
  assign hp1_o   = hp1_q;
  assign hp2_o   = hp2_q;
  assign hp3_o   = hp3_q;
endmodule

// File: rtl/brick_scan.sv
// brick_scan: sweeps the brick health RAM on start and reports per-health tallies
module brick_scan
  import brick_scan_pkg::*;
#(
  parameter int BRICK_NUM  = BRICKNUM,
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 11
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [HEALTH_W-1:0] mem_health,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    bricks_left,
  output logic [CNT_W-1:0]    hp1_cnt,
  output logic [CNT_W-1:0]    hp2_cnt,
  output logic [CNT_W-1:0]    hp3_cnt,
  output logic                level_clear
);
  localparam logic [RD_LATENCY-1:0] VTOP = RD_LATENCY'(1) << (RD_LATENCY - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RD_LATENCY-1:0] vpipe_q, vpipe_d;
  logic [CNT_W-1:0] total, hp1, hp2, hp3;
  logic [CNT_W-1:0] bl_q, hp1_q, hp2_q, hp3_q;
  logic clr_q, clear, pending;
  // only entries behind the output stage matter: the output stage is consumed this cycle
  assign pending = |(vpipe_q & ~VTOP);
  assign clear = state_q == S_IDLE && start;
  assign vpipe_d = (vpipe_q << 1) | RD_LATENCY'(rd_en);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    case (state_q)
      S_IDLE: begin
        state_d = start ? S_READ : S_IDLE;
        addr_d = start ? '0 : addr_q;
      end
      S_READ: begin
        addr_d = addr_q + 1'b1;
        state_d = addr_q == ADDR_W'(BRICK_NUM - 1) ? S_DRAIN : S_READ;
      end
      S_DRAIN: state_d = pending ? S_DRAIN : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      vpipe_q <= '0;
      bl_q    <= '0;
      hp1_q   <= '0;
      hp2_q   <= '0;
      hp3_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      vpipe_q <= vpipe_d;
      if (done) begin
        bl_q  <= total;
        hp1_q <= hp1;
        hp2_q <= hp2;
        hp3_q <= hp3;
        clr_q <= total == '0;
      end
    end
  end
  brick_tally_acc #(.CNT_W(CNT_W)) u_acc (
    .clk      (clk),
    .resetn   (resetn),
    .clear_i  (clear),
    .valid_i  (|(vpipe_q & VTOP)),
    .health_i (mem_health),
    .total_o  (total),
    .hp1_o    (hp1),
    .hp2_o    (hp2),
    .hp3_o    (hp3)
  );
  assign rd_en = state_q == S_READ;
  assign rd_addr = rd_en ? addr_q : '0;
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  // final tallies show through during the done cycle, then the held copy takes over
  assign bricks_left = done ? total : bl_q;
  assign hp1_cnt = done ? hp1 : hp1_q;
  assign hp2_cnt = done ? hp2 : hp2_q;
  assign hp3_cnt = done ? hp3 : hp3_q;
  assign level_clear = done ? total == '0 : clr_q;
endmodule

// File: tb/tb_brick_scan.sv
// tb_brick_scan: two scanners (read latency 1 and 3) against a RAM model and counting reference
module tb_brick_scan;
  localparam int RL [2] = '{1, 3};
  localparam int N = 128;
  logic clk, resetn, start;
  logic [1:0] mh [2];
  logic re [2], bz [2], dn [2], lc [2];
  logic [9:0] ra [2];
  logic [10:0] bl [2], h1 [2], h2 [2], h3 [2];
  logic [1:0] ram [1024];
  logic [3:0] pv [2];
  logic [9:0] pa [2][4];
  logic [44:0] prev [2];
  int tests, fails;

  brick_scan #(.BRICK_NUM(N), .RD_LATENCY(1), .CNT_W(11)) u_l1 (
    .clk(clk), .resetn(resetn), .start(start), .mem_health(mh[0]), .rd_en(re[0]), .rd_addr(ra[0]),
    .busy(bz[0]), .done(dn[0]), .bricks_left(bl[0]), .hp1_cnt(h1[0]), .hp2_cnt(h2[0]),
    .hp3_cnt(h3[0]), .level_clear(lc[0]));
  brick_scan #(.BRICK_NUM(N), .RD_LATENCY(3), .CNT_W(11)) u_l3 (
    .clk(clk), .resetn(resetn), .start(start), .mem_health(mh[1]), .rd_en(re[1]), .rd_addr(ra[1]),
    .busy(bz[1]), .done(dn[1]), .bricks_left(bl[1]), .hp1_cnt(h1[1]), .hp2_cnt(h2[1]),
    .hp3_cnt(h3[1]), .level_clear(lc[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data for a read appears RL cycles later; X when no read is due
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      pv[i] <= {pv[i][2:0], re[i]};
      pa[i][0] <= ra[i];
      for (int j = 1; j < 4; j++) pa[i][j] <= pa[i][j-1];
    end
  always_comb
    for (int i = 0; i < 2; i++) mh[i] = pv[i][RL[i]-1] ? ram[pa[i][RL[i]-1]] : 2'bxx;

  task automatic chk(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [44:0] obs_of(input int i);
    return {lc[i], bl[i], h1[i], h2[i], h3[i]};
  endfunction

  task automatic fill_rand();
    for (int a = 0; a < 1024; a++) ram[a] = 2'($urandom_range(0, 3));
  endtask

  task automatic sweep(input bit pulses, input bit rst_mid);
    int nd [2], nr [2];
    logic [10:0] e1, e2, e3, eb;
    logic [44:0] er;
    e1 = 0; e2 = 0; e3 = 0;
    for (int a = 0; a < N; a++) begin
      if (ram[a] == 2'd1) e1++;
      if (ram[a] == 2'd2) e2++;
      if (ram[a] == 2'd3) e3++;
    end
    eb = e1 + e2 + e3;
    er = {eb == 11'd0, eb, e1, e2, e3};
    nd = '{0, 0};
    nr = '{0, 0};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 260; k++) begin
      for (int i = 0; i < 2; i++) begin
        chk("busy", i, 64'(bz[i]), 64'(k <= N + RL[i] + 1));
        if (re[i]) begin
          chk("rd_addr", i, 64'(ra[i]), 64'(nr[i]));
          nr[i]++;
        end
        if (dn[i]) begin
          nd[i]++;
          chk("done_cycle", i, 64'(k), 64'(N + RL[i] + 1));
          chk("results", i, 64'(obs_of(i)), 64'(er));
          prev[i] = er;
        end else chk("hold", i, 64'(obs_of(i)), 64'(prev[i]));
      end
      start = pulses && (k == 5 || k == 60);
      if (rst_mid && k == 40) begin
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
          prev[i] = '0;
          chk("rst_outputs", i, 64'(obs_of(i)), 64'd0);
          chk("rst_busy", i, 64'({bz[i], re[i], dn[i]}), 64'd0);
        end
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      chk("done_count", i, 64'(nd[i]), 64'd1);
      chk("read_count", i, 64'(nr[i]), 64'(N));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    resetn = 1'b0;
    start = 1'b0;
    for (int a = 0; a < 1024; a++) ram[a] = 2'd0;
    prev = '{45'd0, 45'd0};
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_outputs", i, 64'(obs_of(i)), 64'd0);
      chk("reset_ctrl", i, 64'({re[i], ra[i], bz[i], dn[i]}), 64'd0);
    end
    @(negedge clk);
    for (int a = 17; a <= 31; a++) ram[a] = 2'((a - 17) % 3 + 1);
    ram[49] = 2'd1;
    sweep(1'b0, 1'b0);
    for (int a = 0; a < 1024; a++) ram[a] = 2'd0;
    sweep(1'b0, 1'b0);
    for (int a = 0; a < 1024; a++) ram[a] = 2'd2;
    sweep(1'b0, 1'b0);
    fill_rand();
    sweep(1'b1, 1'b0);
    fill_rand();
    sweep(1'b0, 1'b1);
    fill_rand();
    sweep(1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      sweep(1'b0, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
